// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the DATA_W-bit sample from a fixed-period PWM stream.
// A frame starts on a rising edge and lasts PERIOD clocks. The sample is the number
// of high clocks in the frame. An all-low frame decodes as 0. An all-high frame, or a
// rising edge at the wrong time, is reported as a frame error and clears lock.
module pwm_decoder #(
    parameter int unsigned DATA_W      = 11,
    parameter int unsigned PERIOD      = 2048,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              locked,
    output logic              frame_err,
    output logic [7:0]        err_count
);

    localparam int unsigned PW = DATA_W + 1;
    localparam logic [PW-1:0] C_PERIOD    = PW'(PERIOD);
    localparam logic [PW-1:0] C_PERIOD_M1 = PW'(PERIOD - 1);
    localparam logic [PW-1:0] C_PONE      = PW'(1);
    localparam logic [DATA_W-1:0] C_HONE  = DATA_W'(1);

    typedef enum logic [1:0] {
        SEARCH,
        HIGH,
        LOW,
        ZERO
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;
    logic                   r_lvl_prev;
    logic                   w_rise;

    state_t                 r_state, w_state_nxt;
    logic [PW-1:0]          r_pcnt, w_pcnt_nxt;
    logic [DATA_W-1:0]      r_hcnt, w_hcnt_nxt;
    logic [DATA_W-1:0]      r_sample, w_sample_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_locked, w_locked_nxt;
    logic [7:0]             r_err_count;

    // Synchroniser chain plus the level/previous-level pair for edge detection.
    // Everything resets high so an input already high at release is not seen as a rise.
    // r_lvl registers the last sync stage so the decision sees a full cycle of margin;
    // the output latency is therefore SYNC_STAGES+1 clocks from the first sampling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync     <= '1;
            r_lvl      <= 1'b1;
            r_lvl_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_lvl      <= r_sync[SYNC_STAGES-1];
            r_lvl_prev <= r_lvl;
        end
    end

    assign w_rise = r_lvl & ~r_lvl_prev;

    // Frame decoder next-state logic.
    // r_pcnt holds the number of frame cycles seen before the current one.
    always_comb begin
        w_state_nxt  = r_state;
        w_pcnt_nxt   = r_pcnt;
        w_hcnt_nxt   = r_hcnt;
        w_sample_nxt = r_sample;
        w_valid_nxt  = 1'b0;
        w_err_nxt    = 1'b0;
        w_locked_nxt = r_locked;
        case (r_state)
            SEARCH: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_pcnt_nxt  = C_PONE;
                    w_hcnt_nxt  = C_HONE;
                end
            end
            HIGH: begin
                if (r_lvl) begin
                    // The current cycle is the PERIOD-th and it is still high:
                    // the frame is all-high.
                    if (r_pcnt == C_PERIOD_M1) begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = SEARCH;
                    end else begin
                        w_pcnt_nxt = r_pcnt + C_PONE;
                        w_hcnt_nxt = r_hcnt + C_HONE;
                    end
                end else begin
                    w_pcnt_nxt  = r_pcnt + C_PONE;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (w_rise) begin
                    if (r_pcnt == C_PERIOD) begin
                        w_sample_nxt = r_hcnt;
                        w_valid_nxt  = 1'b1;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                    end
                    w_state_nxt = HIGH;
                    w_pcnt_nxt  = C_PONE;
                    w_hcnt_nxt  = C_HONE;
                end else if (r_pcnt == C_PERIOD) begin
                    w_sample_nxt = r_hcnt;
                    w_valid_nxt  = 1'b1;
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = ZERO;
                    w_pcnt_nxt   = C_PONE;
                end else begin
                    w_pcnt_nxt = r_pcnt + C_PONE;
                end
            end
            ZERO: begin
                if (w_rise) begin
                    if (r_pcnt == C_PERIOD) begin
                        w_sample_nxt = '0;
                        w_valid_nxt  = 1'b1;
                    end else begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                    end
                    w_state_nxt = HIGH;
                    w_pcnt_nxt  = C_PONE;
                    w_hcnt_nxt  = C_HONE;
                end else if (r_pcnt == C_PERIOD) begin
                    w_sample_nxt = '0;
                    w_valid_nxt  = 1'b1;
                    w_pcnt_nxt   = C_PONE;
                end else begin
                    w_pcnt_nxt = r_pcnt + C_PONE;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    // Decoder state, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= SEARCH;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_sample <= w_sample_nxt;
            r_valid  <= w_valid_nxt;
            r_err    <= w_err_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    // Saturating error counter, stepped in the same edge as the frame_err pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign locked       = r_locked;
    assign frame_err    = r_err;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_pwm_decoder.sv
// Testbench for pwm_decoder: directed and random PWM streams, checked against a
// timestamp-based frame model.
module tb_pwm_decoder;

    localparam int DW  = 8;
    localparam int PER = 256;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pwm;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          locked;
    logic          frame_err;
    logic [7:0]    err_count;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_decoder #(
        .DATA_W      (DW),
        .PERIOD      (PER),
        .SYNC_STAGES (SS)
    ) dut (
        .clock        (clk),
        .reset        (rst),
        .pwm_in       (pwm),
        .sample       (sample),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frames are tracked by timestamps of their start and of the falling edge.
    typedef struct {
        int t;
        bit is_err;
        int val;
    } ev_t;

    ev_t q[$];
    int  mode   = 0;   // 0: waiting for a rise, 1: inside a rise-started frame, 2: inside all-low frames
    int  fstart = 0;
    int  fall_t = -1;
    bit  prev   = 1'b1;
    bit  en     = 1'b0;
    int  n      = 0;
    int  rst_at = -1;
    int  e_sample = 0;
    bit  e_locked = 1'b0;
    int  e_errc   = 0;

    task automatic push(input int t, input bit is_err, input int val);
        ev_t e;
        e.t = t + LAT;
        e.is_err = is_err;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic model_step(input bit b, input int t);
        bit rise;
        int age;
        rise = b & ~prev;
        age  = t - fstart + 1;
        case (mode)
            0: begin
                if (rise) begin
                    fstart = t; fall_t = -1; mode = 1;
                end
            end
            1: begin
                if (fall_t < 0) begin
                    if (b) begin
                        if (age == PER) begin
                            push(t, 1'b1, 0); mode = 0;
                        end
                    end else begin
                        fall_t = t;
                    end
                end else if (rise) begin
                    if (age == PER + 1) push(t, 1'b0, fall_t - fstart);
                    else                push(t, 1'b1, 0);
                    fstart = t; fall_t = -1;
                end else if (age == PER + 1) begin
                    push(t, 1'b0, fall_t - fstart);
                    mode = 2; fstart = t;
                end
            end
            default: begin
                if (rise) begin
                    if (age == PER + 1) push(t, 1'b0, 0);
                    else                push(t, 1'b1, 0);
                    mode = 1; fstart = t; fall_t = -1;
                end else if (age == PER + 1) begin
                    push(t, 1'b0, 0);
                    fstart = t;
                end
            end
        endcase
        prev = b;
    endtask

    // Check the outputs of edge n, then feed the model the input for edge n+1.
    always @(negedge clk) begin
        bit   ev_v;
        bit   ev_e;
        ev_t  ev;
        n++;
        if (en) begin
            ev_v = 1'b0;
            ev_e = 1'b0;
            if (n == rst_at) begin
                e_sample = 0; e_locked = 1'b0; e_errc = 0;
            end
            while (q.size() > 0 && q[0].t == n) begin
                ev = q.pop_front();
                if (ev.is_err) begin
                    ev_e = 1'b1; e_locked = 1'b0;
                    if (e_errc < 255) e_errc++;
                end else begin
                    ev_v = 1'b1; e_sample = ev.val; e_locked = 1'b1;
                end
            end
            chk("sample_valid", 32'(sample_valid), 32'(ev_v));
            chk("frame_err",    32'(frame_err),    32'(ev_e));
            chk("sample",       32'(sample),       32'(e_sample));
            chk("locked",       32'(locked),       32'(e_locked));
            chk("err_count",    32'(err_count),    32'(e_errc));
        end
        if (rst) begin
            q.delete();
            mode = 0; prev = 1'b1; fall_t = -1;
            rst_at = n + 1;
            en = 1'b1;
        end else if (en) begin
            model_step(pwm, n + 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int k);
        pwm = v;
        cyc(k);
    endtask

    task automatic frame(input int h);
        hold(1'b1, h);
        hold(1'b0, PER - h);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        pwm = 1'b0;
        cyc(3);
        rst = 1'b0;
        hold(1'b0, 20);

        // steady value 5
        repeat (4) frame(5);

        // extreme duty values
        frame(PER - 1);
        chk("t1_sample", 32'(sample), 32'd5);
        chk("t1_locked", 32'(locked), 32'd1);
        frame(1);
        chk("t2_sample", 32'(sample), 32'(PER - 1));

        // value, then all-low frames, then value again
        frame(100);
        hold(1'b0, 3 * PER);
        frame(200);
        chk("t3_locked", 32'(locked), 32'd1);

        // early rising edge
        hold(1'b1, 50);
        hold(1'b0, 150);
        hold(1'b1, 10);
        chk("t4_errc",   32'(err_count), 32'd1);
        chk("t4_locked", 32'(locked),    32'd0);
        hold(1'b0, PER - 10);
        frame(90);

        // stuck high, then a burst of short malformed frames
        hold(1'b1, 700);
        hold(1'b0, 30);
        repeat (300) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 10);
        chk("t5_errc_sat", 32'(err_count), 32'd255);
        frame(33);
        frame(44);

        // reset in the middle of a high phase
        frame(60);
        hold(1'b1, 20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_sample", 32'(sample),       32'd0);
        chk("t6_valid",  32'(sample_valid), 32'd0);
        chk("t6_locked", 32'(locked),       32'd0);
        chk("t6_errc",   32'(err_count),    32'd0);
        hold(1'b1, 20);
        hold(1'b0, 200);
        frame(120);
        frame(130);

        // random frames with occasional malformed segments
        repeat (40) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(1'b1, $urandom_range(1, PER + 50));
                hold(1'b0, $urandom_range(1, PER));
            end else if (r == 1) begin
                frame(PER - 1);
            end else if (r == 2) begin
                frame($urandom_range(0, 2));
            end else begin
                frame($urandom_range(0, PER - 1));
            end
        end
        frame(50);
        hold(1'b0, 3 * PER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
